pe_rr_arbiter: RTL and testbench
================================

# pe_rr_arbiter

Round-robin scheduler that shares one PE input port among `DEPTH` requesters. It grants one requester at a time and drives the `sel` input of the PE operand multiplexer. It presents a single valid/ready stream toward the PE and returns per-requester ready. The block sits between the requester FIFOs and the operand mux; data never passes through it, only control.

## Interface
Parameters:
- `DEPTH`, 8: number of requesters (any value ≥ 2, power of two not required)
- `SEL_WIDTH`, `$clog2(DEPTH)`: select width, must match the operand mux
- `BURST_LEN`, 4: maximum beats per grant when burst mode is compiled in (≥ 1)

Ports:
- `clk`  in  1  clock; all logic is on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  arbitration enable; low blocks new grants, and an active grant still completes
- `req_valid`  in  DEPTH  per-requester valid; held high until that requester's handshake
- `req_ready`  out  DEPTH  per-requester ready; one-hot or zero
- `sel`  out  SEL_WIDTH  registered select to the operand mux
- `out_valid`  out  1  stream valid toward the PE
- `out_ready`  in  1  PE ready
- `busy`  out  1  a grant is held
- `grant_cnt`  out  16  count of completed handshakes, wraps at 2^16

## Operation
- State: `IDLE` (`busy=0`) or `GRANT` (`busy=1`, `sel` holds the granted index). Registers are `sel`, `busy`, `ptr`, `grant_cnt`, and `beat` (burst mode only).
- Round-robin pick: first index i with `req_valid[i]=1`, searching from `ptr` upward modulo DEPTH. `ptr` is the priority head.
- IDLE → GRANT: when `en=1` and some `req_valid` is high, register `sel=i`, `busy=1`, `ptr=(i+1) mod DEPTH`. Wrap is explicit, DEPTH-1 → 0, including non-power-of-two DEPTH.
- Combinational outputs:
  - `out_valid = busy & req_valid[sel]`
  - `req_ready[k] = busy & (k==sel) & out_ready`
- Handshake: the cycle in which `out_valid & out_ready`. On it, `grant_cnt` increments.
- Release on handshake, non-burst:
  - Re-pick immediately over `req_valid & ~onehot(sel)`, gated by `en`. If a winner exists, the new grant is registered with no bubble.
  - Otherwise go to IDLE.
  - The just-served requester cannot win back-to-back. It re-competes after one IDLE cycle.
- `en` low during GRANT: the current beat completes normally. No re-pick follows; the block goes to IDLE.
- A requester dropping `req_valid` before its handshake is a protocol violation. The arbiter then releases to IDLE at the next edge, with no handshake counted.
- Reset mid-grant: all state returns to reset values at the next edge. `req_ready` drops combinationally with `busy`.

## Timing
- Reset values: `sel=0`, `busy=0`, `ptr=0`, `grant_cnt=0`, `beat=0`. Therefore `out_valid=0` and `req_ready=0`.
- Grant latency from IDLE: request at edge t gives `out_valid` at t+1.
- Throughput: 1 beat/cycle while different requesters alternate. A sole requester gets 1 beat per 2 cycles (non-burst).
- When `sel` changes, it changes only on an edge, so the mux output is stable within a cycle.
- `out_ready` high with `out_valid` low has no effect.

## Configuration
- Macro: `PE_RR_ARBITER_BURST_EN`.
- Defined:
  - On handshake, if `beat < BURST_LEN-1`, keep the grant and increment `beat`.
  - On the handshake with `beat == BURST_LEN-1`, release as above and clear `beat`.
  - If `req_valid[sel]` is low on a granted cycle (requester has no next beat), release to IDLE or re-pick, and clear `beat`.
- Undefined: the `beat` register is absent, and every handshake releases the grant.

## Structure
- Shared package `pe_pkg`:
  - typedef `pe_sel_t` (`logic [SEL_WIDTH-1:0]`)
  - enum `pe_arb_state_e` {`ARB_IDLE`, `ARB_GRANT`}
  - constant `PE_ARB_CNT_W = 16`
- Sub-module `pe_rr_pick`: combinational rotate-priority finder, with inputs `req`, `ptr` and outputs `found`, `idx`. It is instantiated once.

## Test plan
- DEPTH=4, reset then `req_valid=4'b1111`, `out_ready=1`:
  - `sel` sequence is 0,1,2,3,0,… with no bubbles
  - `grant_cnt=8` after 8 beats
- Only requester 2 valid, `out_ready=1` → handshakes every other cycle, `sel` stays 2, `busy` toggles 1,0,1,0.
- Grant to 1 with `out_ready=0` for 5 cycles → `out_valid` held high, `req_ready=0`. When ready rises, `req_ready=4'b0010` for exactly 1 cycle.
- `en` dropped during a grant to 3 while 0 is requesting → the beat for 3 completes, then IDLE. `en` reasserted → grant to 0 one cycle later.
- `rst` pulsed mid-grant (`sel=2`, `ptr=3`) → next cycle `sel=0`, `ptr=0`, `busy=0`, `grant_cnt=0`.
- `PE_RR_ARBITER_BURST_EN`, BURST_LEN=4, requesters 0 and 1 always valid → `sel` gives 4 beats of 0, then 4 beats of 1, then repeats.

Source files
------------

// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared types and constants for the PE round-robin arbiter
package pe_pkg;

    localparam int PE_DEPTH     = 8;
    localparam int PE_SEL_WIDTH = $clog2(PE_DEPTH);
    localparam int PE_ARB_CNT_W = 16;

    typedef logic [PE_SEL_WIDTH-1:0] pe_sel_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } pe_arb_state_e;

endpackage

// File: rtl/pe_rr_pick.sv
// rtl/pe_rr_pick.sv - combinational rotate-priority finder: first set req bit at or after ptr
module pe_rr_pick #(
    parameter int DEPTH     = 8,
    parameter int SEL_WIDTH = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]     req,
    input  logic [SEL_WIDTH-1:0] ptr,
    output logic                 found,
    output logic [SEL_WIDTH-1:0] idx
);

    logic [SEL_WIDTH:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (SEL_WIDTH + 1)'(k);
            if (cand >= (SEL_WIDTH + 1)'(DEPTH)) begin
                cand = cand - (SEL_WIDTH + 1)'(DEPTH);
            end
            if (req[cand[SEL_WIDTH-1:0]]) begin
                found = 1'b1;
                idx   = cand[SEL_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/pe_rr_arbiter.sv
// rtl/pe_rr_arbiter.sv - round-robin grant/select control for one PE input port; PE_RR_ARBITER_BURST_EN enables multi-beat grants
module pe_rr_arbiter
    import pe_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int SEL_WIDTH = $clog2(DEPTH),
    parameter int BURST_LEN = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [DEPTH-1:0]        req_valid,
    output logic [DEPTH-1:0]        req_ready,
    output logic [SEL_WIDTH-1:0]    sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic [PE_ARB_CNT_W-1:0] grant_cnt
);

    pe_arb_state_e        state, state_n;
    logic [SEL_WIDTH-1:0] sel_n;
    logic [SEL_WIDTH-1:0] ptr, ptr_n;
    logic [DEPTH-1:0]     sel_mask;
    logic [DEPTH-1:0]     pick_req;
    logic                 pick_found;
    logic [SEL_WIDTH-1:0] pick_idx;
    logic                 do_pick;
    logic                 hs;

`ifdef PE_RR_ARBITER_BURST_EN
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    logic [BEAT_W-1:0] beat, beat_n;
`endif

    assign busy      = (state == ARB_GRANT);
    assign sel_mask  = DEPTH'(1) << sel;
    assign out_valid = busy & req_valid[sel];
    assign req_ready = (busy & out_ready) ? sel_mask : '0;
    assign hs        = out_valid & out_ready;

    // While granted, the current owner is masked so it cannot win back-to-back.
    assign pick_req = busy ? (req_valid & ~sel_mask) : req_valid;

    pe_rr_pick #(
        .DEPTH     (DEPTH),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_pick (
        .req   (pick_req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_n = state;
        sel_n   = sel;
        ptr_n   = ptr;
        do_pick = 1'b0;
`ifdef PE_RR_ARBITER_BURST_EN
        beat_n  = beat;
`endif
        case (state)
            ARB_IDLE: begin
                do_pick = en;
            end
            ARB_GRANT: begin
`ifdef PE_RR_ARBITER_BURST_EN
                if (!req_valid[sel] || (out_ready && beat == BEAT_W'(BURST_LEN - 1))) begin
                    state_n = ARB_IDLE;
                    beat_n  = '0;
                    do_pick = en;
                end else if (out_ready) begin
                    beat_n = beat + BEAT_W'(1);
                end
`else
                if (!req_valid[sel]) begin
                    state_n = ARB_IDLE;
                end else if (out_ready) begin
                    state_n = ARB_IDLE;
                    do_pick = en;
                end
`endif
            end
            default: state_n = ARB_IDLE;
        endcase

        if (do_pick && pick_found) begin
            state_n = ARB_GRANT;
            sel_n   = pick_idx;
            ptr_n   = (pick_idx == SEL_WIDTH'(DEPTH - 1)) ? '0 : pick_idx + SEL_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            sel       <= '0;
            ptr       <= '0;
            grant_cnt <= '0;
`ifdef PE_RR_ARBITER_BURST_EN
            beat      <= '0;
`endif
        end else begin
            state <= state_n;
            sel   <= sel_n;
            ptr   <= ptr_n;
            if (hs) begin
                grant_cnt <= grant_cnt + PE_ARB_CNT_W'(1);
            end
`ifdef PE_RR_ARBITER_BURST_EN
            beat  <= beat_n;
`endif
        end
    end

endmodule

// File: tb/tb_pe_rr_arbiter.sv
// tb/tb_pe_rr_arbiter.sv - directed-vector bench for pe_rr_arbiter with DEPTH=4
module tb_pe_rr_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [1:0]  sel;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic [15:0] grant_cnt;

    int n_vec = 0;
    int n_err = 0;

    pe_rr_arbiter #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .grant_cnt (grant_cnt)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        req_valid = 4'b0000;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        settle();
        expect_eq("rst_sel", 32'(sel), 32'd0);
        expect_eq("rst_busy", 32'(busy), 32'd0);
        expect_eq("rst_ovalid", 32'(out_valid), 32'd0);
        expect_eq("rst_rready", 32'(req_ready), 32'd0);
        expect_eq("rst_cnt", 32'(grant_cnt), 32'd0);

        // Ready with nothing valid does nothing
        out_ready = 1'b1;
        tick();
        expect_eq("idle_ready_cnt", 32'(grant_cnt), 32'd0);
        expect_eq("idle_ready_busy", 32'(busy), 32'd0);

        // All four requesting: 0,1,2,3,0,1,2,3 with no bubbles
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            expect_eq($sformatf("rr_sel%0d", i), 32'(sel), 32'(i % 4));
            expect_eq($sformatf("rr_busy%0d", i), 32'(busy), 32'd1);
        end
        expect_eq("rr_cnt7", 32'(grant_cnt), 32'd7);
        tick();
        expect_eq("rr_cnt8", 32'(grant_cnt), 32'd8);
        expect_eq("rr_sel_wrap", 32'(sel), 32'd0);

        // Owner drops valid before handshake: release with no count
        req_valid = 4'b0000;
        settle();
        expect_eq("drop_ovalid", 32'(out_valid), 32'd0);
        tick();
        expect_eq("drop_busy", 32'(busy), 32'd0);
        expect_eq("drop_cnt", 32'(grant_cnt), 32'd8);

        // Sole requester 2: busy alternates, sel stays 2
        req_valid = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_eq($sformatf("solo_busy%0d", i), 32'(busy), (i % 2 == 0) ? 32'd1 : 32'd0);
            expect_eq($sformatf("solo_sel%0d", i), 32'(sel), 32'd2);
        end
        expect_eq("solo_cnt", 32'(grant_cnt), 32'd10);

        // Stall on grant to 1
        req_valid = 4'b0010;
        out_ready = 1'b0;
        tick();
        expect_eq("stall_sel", 32'(sel), 32'd1);
        for (int i = 0; i < 5; i++) begin
            expect_eq($sformatf("stall_ov%0d", i), 32'(out_valid), 32'd1);
            expect_eq($sformatf("stall_rr%0d", i), 32'(req_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        settle();
        expect_eq("stall_rr_hs", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b0000;
        settle();
        expect_eq("stall_rr_after", 32'(req_ready), 32'd0);
        expect_eq("stall_busy_after", 32'(busy), 32'd0);
        expect_eq("stall_cnt", 32'(grant_cnt), 32'd11);

        // en dropped during a grant to 3 while 0 is requesting
        req_valid = 4'b1001;
        out_ready = 1'b0;
        tick();
        expect_eq("en_sel3", 32'(sel), 32'd3);
        en        = 1'b0;
        out_ready = 1'b1;
        tick();
        expect_eq("en_busy_off", 32'(busy), 32'd0);
        expect_eq("en_cnt", 32'(grant_cnt), 32'd12);
        req_valid = 4'b0001;
        tick();
        expect_eq("en_hold_idle", 32'(busy), 32'd0);
        en = 1'b1;
        tick();
        expect_eq("en_regrant_busy", 32'(busy), 32'd1);
        expect_eq("en_regrant_sel", 32'(sel), 32'd0);
        expect_eq("en_regrant_ov", 32'(out_valid), 32'd1);

        // Handshake on 0 re-picks 2, then reset mid-grant
        req_valid = 4'b0101;
        tick();
        expect_eq("pre_rst_sel", 32'(sel), 32'd2);
        expect_eq("pre_rst_ptr", 32'(dut.ptr), 32'd3);
        expect_eq("pre_rst_cnt", 32'(grant_cnt), 32'd13);
        out_ready = 1'b0;
        rst       = 1'b1;
        tick();
        expect_eq("mid_rst_sel", 32'(sel), 32'd0);
        expect_eq("mid_rst_ptr", 32'(dut.ptr), 32'd0);
        expect_eq("mid_rst_busy", 32'(busy), 32'd0);
        expect_eq("mid_rst_cnt", 32'(grant_cnt), 32'd0);
        expect_eq("mid_rst_rready", 32'(req_ready), 32'd0);
        rst = 1'b0;

        // Requesters 0 and 1 always valid
        req_valid = 4'b0011;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
`ifdef PE_RR_ARBITER_BURST_EN
            expect_eq($sformatf("pair_sel%0d", i), 32'(sel), 32'((i / 4) % 2));
`else
            expect_eq($sformatf("pair_sel%0d", i), 32'(sel), 32'(i % 2));
`endif
        end
        expect_eq("pair_cnt", 32'(grant_cnt), 32'd11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
